// File: rtl/rho_rotate_pkg.sv
// Shared constants for the slice-organised permutation datapath: geometry,
// FSM encoding and the per-lane rho rotation offsets.
package rho_rotate_pkg;

  localparam int W      = 25;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  typedef logic [0:W-1]        slice_t;
  typedef logic [ADDR_W-1:0]   addr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  // Rotation offset per lane, indexed by lane = x + 5*y
  localparam addr_t RHO_OFF [W] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  function automatic int lane_idx(input int x, input int y);
    return x + 5 * y;
  endfunction

endpackage

// File: rtl/rho_rotate_slice_sel.sv
// Combinational rho selector: builds output slice z by picking, for every
// lane, the bit stored at slice (z - offset) mod 64 of the local array.
module rho_slice_sel
  import rho_rotate_pkg::*;
(
  input  slice_t i_slices [DEPTH],
  input  addr_t  i_z,
  output slice_t o_slice
);

  for (genvar gi = 0; gi < W; gi++) begin : g_lane
    addr_t w_src;
    // Modulo-64 wrap comes for free from the 6-bit subtract
    assign w_src       = i_z - RHO_OFF[gi];
    assign o_slice[gi] = i_slices[w_src][gi];
  end

endmodule

// File: rtl/rho_rotate.sv
// Rho lane-rotate stage: loads 64 slices from the column-parity buffer into a
// local register array, then writes the 64 rotated slices downstream.
module rho_rotate
  import rho_rotate_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  output logic   ready,
  output logic   busy,
  output logic   rd_en,
  output addr_t  rd_addr,
  input  slice_t rd_data,
  output logic   wr_en,
  output addr_t  wr_addr,
  output slice_t wr_data
);

  state_t r_state;
  state_t w_next;
  addr_t  r_cnt;
  logic   r_vld_p1;
  addr_t  r_addr_p1;
  slice_t r_local [DEPTH];
  slice_t w_rot;

  rho_slice_sel u_sel (
    .i_slices (r_local),
    .i_z      (r_cnt),
    .o_slice  (w_rot)
  );

  // Control registers: state, shared slice counter, read-return tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_vld_p1  <= 1'b0;
      r_addr_p1 <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_LOAD || r_state == S_WRITE) begin
        r_cnt <= r_cnt + addr_t'(1);
      end else begin
        r_cnt <= '0;
      end
      // p0 -> p1: read request becomes a data-return one cycle later
      r_vld_p1  <= rd_en;
      r_addr_p1 <= rd_addr;
    end
  end

  // Local slice store; capture returned read data (not cleared by reset)
  always_ff @(posedge clk) begin
    if (r_vld_p1) begin
      r_local[r_addr_p1] <= rd_data;
    end
  end

  // Next-state and output decode from the registered state and counter
  always_comb begin
    w_next  = r_state;
    ready   = 1'b0;
    busy    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = r_cnt;
        if (r_cnt == addr_t'(DEPTH - 1)) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        w_next = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = r_cnt;
        wr_data = w_rot;
        if (r_cnt == addr_t'(DEPTH - 1)) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        ready  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rho_rotate.sv
// Bench for rho_rotate: upstream/downstream buffer models, rho reference
// model feeding a write scoreboard, per-pass timing checks.
module tb_rho_rotate;

  logic        clk;
  logic        rst;
  logic        start;
  logic        ready;
  logic        busy;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [0:24] rd_data;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [0:24] wr_data;

  rho_rotate dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ready   (ready),
    .busy    (busy),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rho offsets, first index x, second index y
  int rho_xy [5][5] = '{'{0, 36, 3, 41, 18},
                        '{1, 44, 10, 45, 2},
                        '{62, 6, 43, 15, 61},
                        '{28, 55, 25, 21, 56},
                        '{27, 20, 39, 8, 14}};

  logic [0:24] mem_in  [64];
  logic [0:24] mem_out [64];

  int n_chk;
  int n_err;
  bit sb_en;

  typedef struct {
    logic [5:0]  addr;
    logic [0:24] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    int z_in;
    int lane;
    int z_out;
  } vec_t;
  vec_t tbl [7];

  // Upstream buffer: data valid one cycle after the read strobe
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem_in[rd_addr];
  end

  // Downstream buffer
  always @(posedge clk) begin
    if (wr_en) mem_out[wr_addr] <= wr_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every downstream write is matched against the model
  always @(negedge clk) begin
    if (wr_en && sb_en) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_write", 64'(wr_addr), 64'hFFFF);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("sb_wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("sb_wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  function automatic logic [0:24] model_slice(input int z);
    logic [0:24] w;
    int src;
    for (int i = 0; i < 25; i++) begin
      src  = (z - rho_xy[i % 5][i / 5]) & 63;
      w[i] = mem_in[src][i];
    end
    return w;
  endfunction

  task automatic push_expected();
    sb_t e;
    for (int z = 0; z < 64; z++) begin
      e.addr = 6'(z);
      e.data = model_slice(z);
      sb_q.push_back(e);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"},   64'(ready),   64'd0);
    chk({tag, "_busy"},    64'(busy),    64'd0);
    chk({tag, "_rd_en"},   64'(rd_en),   64'd0);
    chk({tag, "_wr_en"},   64'(wr_en),   64'd0);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
  endtask

  // One full pass; start is sampled at cycle 0, negedge k samples cycle k
  task automatic run_pass(input bit pulse_ign);
    int b_rden, b_rdaddr, b_wren, b_wraddr, b_ready, b_busy, b_ovl;
    b_rden = 0; b_rdaddr = 0; b_wren = 0; b_wraddr = 0;
    b_ready = 0; b_busy = 0; b_ovl = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 132; k++) begin
      @(negedge clk);
      if (rd_en !== (k >= 1 && k <= 64)) b_rden++;
      if (k <= 64 && rd_addr !== 6'(k - 1)) b_rdaddr++;
      if (wr_en !== (k >= 66 && k <= 129)) b_wren++;
      if (k >= 66 && k <= 129 && wr_addr !== 6'(k - 66)) b_wraddr++;
      if (ready !== (k == 130)) b_ready++;
      if (busy !== (k <= 130)) b_busy++;
      if (rd_en && wr_en) b_ovl++;
      start = pulse_ign && (k == 10 || k == 129);
    end
    start = 1'b0;
    chk("pass_rd_en_window",  64'(b_rden),   64'd0);
    chk("pass_rd_addr_seq",   64'(b_rdaddr), 64'd0);
    chk("pass_wr_en_window",  64'(b_wren),   64'd0);
    chk("pass_wr_addr_seq",   64'(b_wraddr), 64'd0);
    chk("pass_ready_at_130",  64'(b_ready),  64'd0);
    chk("pass_busy_window",   64'(b_busy),   64'd0);
    chk("pass_rd_wr_overlap", 64'(b_ovl),    64'd0);
    chk("pass_sb_drained",    64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    logic [0:24] w;
    int ones;
    int stray;
    n_chk = 0;
    n_err = 0;
    sb_en = 1'b1;
    rst   = 1'b1;
    start = 1'b0;
    tbl[0] = '{z_in: 0,  lane: 1,  z_out: 1};
    tbl[1] = '{z_in: 5,  lane: 2,  z_out: 3};
    tbl[2] = '{z_in: 63, lane: 5,  z_out: 35};
    tbl[3] = '{z_in: 10, lane: 0,  z_out: 10};
    tbl[4] = '{z_in: 0,  lane: 24, z_out: 14};
    tbl[5] = '{z_in: 60, lane: 3,  z_out: 24};
    tbl[6] = '{z_in: 20, lane: 12, z_out: 63};

    // Reset out of power-up
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_init");

    // All-ones timing pass
    for (int z = 0; z < 64; z++) mem_in[z] = '1;
    push_expected();
    run_pass(1'b0);

    // Reset for 3 cycles while idle
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset_idle_held");
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_idle");

    // Single-bit vectors, including wrap-around offsets
    for (int t = 0; t < 7; t++) begin
      for (int z = 0; z < 64; z++) mem_in[z] = '0;
      mem_in[tbl[t].z_in][tbl[t].lane] = 1'b1;
      push_expected();
      run_pass(1'b0);
      w = '0;
      w[tbl[t].lane] = 1'b1;
      chk($sformatf("vec%0d_out_slice", t), 64'(mem_out[tbl[t].z_out]), 64'(w));
      ones = 0;
      for (int z = 0; z < 64; z++)
        for (int i = 0; i < 25; i++) ones += int'(mem_out[z][i]);
      chk($sformatf("vec%0d_popcount", t), 64'(ones), 64'd1);
    end

    // Start pulses during LOAD and on the last WRITE cycle are ignored
    for (int z = 0; z < 64; z++) mem_in[z] = 25'($urandom);
    push_expected();
    run_pass(1'b1);

    // Reset mid-pass during WRITE
    for (int z = 0; z < 64; z++) mem_in[z] = 25'($urandom);
    sb_en = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 70; k++) @(negedge clk);
    chk("midrst_wr_en_before", 64'(wr_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("midrst_after");
    stray = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (rd_en || wr_en || busy || ready) stray++;
    end
    chk("midrst_quiet", 64'(stray), 64'd0);
    sb_en = 1'b1;
    push_expected();
    run_pass(1'b0);

    // Random states
    for (int n = 0; n < 50; n++) begin
      for (int z = 0; z < 64; z++) mem_in[z] = 25'($urandom);
      push_expected();
      run_pass(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
